// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings, pointer-width rule and the
// status-flag bundle common to the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned fifo_ptr_bits(input int unsigned addr_bits);
    return addr_bits + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
// The array has no reset; contents are only meaningful behind valid pointers.
module fifo_mem_2p #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, programmable almost-full/almost-empty, flush and sticky error flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH),
  parameter int unsigned FWFT       = FIFO_MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  input  logic [ADDR_BITS:0]    af_thresh,
  input  logic [ADDR_BITS:0]    ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = fifo_ptr_bits(ADDR_BITS);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic                  wr_acc, rd_acc, wr_err, rd_err;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_flags_t           flags;

  assign count_q = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                   (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);

  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_err = wr_en && full   && !flush;
  assign rd_err = rd_en && empty  && !flush;

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_BITS-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[ADDR_BITS-1:0]),
    .rd_data (mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = (overflow_q  && !clr_err) || wr_err;
    underflow_d = (underflow_q && !clr_err) || rd_err;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
      end
    end

    // Almost flags are registered from the next count so they line up with
    // count while keeping the threshold inputs off any combinational output path.
    count_d        = wr_ptr_d - rd_ptr_d;
    almost_full_d  = (count_d >= af_thresh);
    almost_empty_d = (count_d <= ae_thresh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      almost_full_q  <= (af_thresh == '0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  always_comb begin
    flags.full         = full;
    flags.empty        = empty;
    flags.almost_full  = almost_full_q;
    flags.almost_empty = almost_empty_q;
    flags.overflow     = overflow_q;
    flags.underflow    = underflow_q;
  end

  assign wr_full      = flags.full;
  assign rd_empty     = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign overflow     = flags.overflow;
  assign underflow    = flags.underflow;
  assign count        = count_q;

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word shown directly; forced to zero while empty so stale array
      // contents never appear on the bus.
      assign rd_data  = empty ? '0 : mem_rdata;
      assign rd_valid = !empty;
    end else begin : g_std
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: one standard-read and one FWFT instance driven by the
// same stimulus, checked against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AB    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [AB:0]   af_thresh = 5'd14;
  logic [AB:0]   ae_thresh = 5'd2;

  logic          s_full, s_valid, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [DW-1:0] s_data;
  logic [AB:0]   s_count;
  logic          f_full, f_valid, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [DW-1:0] f_data;
  logic [AB:0]   f_count;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(s_full), .rd_en(rd_en), .rd_data(s_data), .rd_valid(s_valid),
    .rd_empty(s_empty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .clr_err(clr_err), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(f_full), .rd_en(rd_en), .rd_data(f_data), .rd_valid(f_valid),
    .rd_empty(f_empty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .clr_err(clr_err), .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
  logic [DW-1:0] rd_hold = '0;

  typedef struct {
    logic          we;
    logic          re;
    logic [DW-1:0] wd;
    logic [AB:0]   af;
    logic [AB:0]   ae;
    logic [AB:0]   cnt;
    logic          xaf;
    logic          xae;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic we, input logic re,
                       input logic fl, input logic ce, input logic [DW-1:0] wd);
    int  sz;
    logic wacc, racc;
    rst = r; wr_en = we; rd_en = re; flush = fl; clr_err = ce; wr_data = wd;
    sz = model.size();
    if (r) begin
      model.delete(); exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0; rd_hold = '0;
    end else begin
      m_ovf = (m_ovf && !ce) || (we && sz == DEPTH && !fl);
      m_unf = (m_unf && !ce) || (re && sz == 0 && !fl);
      m_vld = 1'b0;
      if (fl) begin
        model.delete();
      end else begin
        wacc = we && sz < DEPTH;
        racc = re && sz > 0;
        if (racc) begin
          exp_q.push_back(model.pop_front());
          m_vld = 1'b1;
        end
        if (wacc) model.push_back(wd);
      end
    end
    @(posedge clk);
    #1;
    sz = model.size();
    chk("count", 32'(s_count), 32'(sz));
    chk("rd_empty", 32'(s_empty), 32'(sz == 0));
    chk("wr_full", 32'(s_full), 32'(sz == DEPTH));
    chk("almost_full", 32'(s_af), 32'(sz >= int'(af_thresh)));
    chk("almost_empty", 32'(s_ae), 32'(sz <= int'(ae_thresh)));
    chk("overflow", 32'(s_ovf), 32'(m_ovf));
    chk("underflow", 32'(s_unf), 32'(m_unf));
    chk("rd_valid", 32'(s_valid), 32'(m_vld));
    if (s_valid) begin
      if (exp_q.size() > 0) begin
        rd_hold = exp_q.pop_front();
      end else begin
        total++; bad++;
        $display("FAIL sb_unexpected: rd_valid=1 with no expected word, rd_data=%0h", s_data);
      end
    end
    exp_q.delete();
    chk("rd_data", 32'(s_data), 32'(rd_hold));
    chk("fwft_count", 32'(f_count), 32'(sz));
    chk("fwft_rd_valid", 32'(f_valid), 32'(sz > 0));
    chk("fwft_rd_data", 32'(f_data), 32'((sz > 0) ? model[0] : 8'h00));
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h11, 5'd2, 5'd1,  5'd1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'h12, 5'd2, 5'd1,  5'd2, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h13, 5'd2, 5'd1,  5'd3, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 5'd4, 5'd1,  5'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 5'd0, 5'd1,  5'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 5'd4, 5'd16, 5'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 5'd4, 5'd2,  5'd1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'h14, 5'd4, 5'd0,  5'd1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 5'd4, 5'd0,  5'd0, 1'b0, 1'b1};

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);

    // Threshold table
    for (int i = 0; i < 9; i++) begin
      af_thresh = tbl[i].af;
      ae_thresh = tbl[i].ae;
      cycle(1'b0, tbl[i].we, tbl[i].re, 1'b0, 1'b0, tbl[i].wd);
      chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_af", i), 32'(s_af), 32'(tbl[i].xaf));
      chk($sformatf("tbl%0d_ae", i), 32'(s_ae), 32'(tbl[i].xae));
    end
    af_thresh = 5'd14;
    ae_thresh = 5'd2;

    // Fill to full, then overflow attempt
    for (int i = 1; i <= 16; i++) cycle(0, 1, 0, 0, 0, 8'(i));
    chk("fill_full", 32'(s_full), 32'd1);
    chk("fill_count", 32'(s_count), 32'd16);
    cycle(0, 1, 1'b0, 0, 0, 8'hAA);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    cycle(0, 1, 1, 0, 0, 8'hAB);

    // Drain, underflow, clr_err vs same-cycle error, then clear
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 0, 8'h00);
    chk("unf_set", 32'(s_unf), 32'd1);
    cycle(0, 1'b0, 1, 0, 1, 8'h00);
    chk("unf_wins_clr", 32'(s_unf), 32'd1);
    cycle(0, 0, 0, 0, 1, 8'h00);
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    chk("clr_unf", 32'(s_unf), 32'd0);

    // FWFT single word
    cycle(0, 1, 0, 0, 0, 8'h55);
    chk("fwft_55", 32'(f_data), 32'h55);
    cycle(0, 0, 1, 0, 0, 8'h00);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);

    // Fill to 8, then streaming read+write across pointer wraps
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) cycle(0, 1, 1, 0, 0, 8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);

    // Flush keeps sticky errors, clears contents
    cycle(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 8'hC0 + 8'(i));
    cycle(0, 1, 1, 1, 0, 8'hEE);
    chk("flush_unf_kept", 32'(s_unf), 32'd1);
    cycle(0, 1, 0, 0, 1, 8'h33);
    cycle(0, 0, 1, 0, 0, 8'h00);
    chk("flush_first", 32'(s_data), 32'h33);
    cycle(0, 0, 0, 0, 0, 8'h00);

    // Reset overrides a same-cycle write
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 8'h60 + 8'(i));
    cycle(1, 1, 0, 0, 0, 8'h77);
    chk("rst_count", 32'(s_count), 32'd0);
    cycle(0, 0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
